// File: rtl/dma_reader.sv
// Avalon-MM read engine: walks a strided line/region pattern through a circular
// sample window and streams the returned words out through a show-ahead FIFO.
module dma_reader #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] start_addr_block,
   input  logic [31:0] stop_addr_block,
   input  logic [31:0] start_addr_read,
   input  logic [15:0] data_len,
   input  logic [15:0] line_width,
   input  logic [15:0] region_width,
   output logic [31:0] avm_m0_address,
   output logic        avm_m0_read,
   input  logic        avm_m0_waitrequest,
   input  logic [31:0] avm_m0_readdata,
   input  logic        avm_m0_readdatavalid,
   output logic [31:0] stream_data,
   output logic        stream_valid,
   input  logic        stream_ready,
   output logic        busy,
   output logic        irq
);

   localparam int          AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [16:0] CREDIT = 17'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t        state, state_nx;
   logic [31:0]   blk_start, blk_stop, addr, line_base;
   logic [15:0]   len, lw, rw, col, issued, received, pending;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          push, pop, accept, last_accept, credit_ok;

   // Single-correction wrap into the circular window [lo, hi).
   function automatic logic [31:0] wrap(input logic [31:0] x, input logic [31:0] lo,
                                        input logic [31:0] hi);
      return (x >= hi) ? x - hi + lo : x;
   endfunction

   // Outstanding reads plus buffered words never exceed the FIFO depth, so a
   // returned word always has a slot waiting for it.
   assign pending        = issued - received;
   assign credit_ok      = ({1'b0, pending} + 17'(count)) < CREDIT;
   assign avm_m0_read    = (state == ISSUE) && credit_ok;
   assign avm_m0_address = addr;
   assign accept         = avm_m0_read && !avm_m0_waitrequest;
   assign last_accept    = accept && (issued + 16'd1 == len);
   assign push           = avm_m0_readdatavalid && (state != IDLE);
   assign stream_valid   = (count != '0);
   assign pop            = stream_valid && stream_ready;
   assign stream_data    = stream_valid ? mem[rd_ptr] : '0;

   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (start) state_nx = (data_len == 16'd0) ? DONE : ISSUE;
         ISSUE: if (last_accept) state_nx = DRAIN;
         DRAIN: if (received == len && count == '0) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of the order statements execute in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         irq   <= 1'b0;
      end else begin
         state <= state_nx;
         busy  <= (state_nx != IDLE);
         irq   <= (state_nx == DONE);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blk_start <= '0;
         blk_stop  <= '0;
         len       <= '0;
         lw        <= '0;
         rw        <= '0;
         addr      <= '0;
         line_base <= '0;
         col       <= '0;
         issued    <= '0;
         received  <= '0;
      end else if (state == IDLE) begin
         if (start) begin
            blk_start <= start_addr_block;
            blk_stop  <= stop_addr_block;
            len       <= data_len;
            lw        <= line_width;
            rw        <= region_width;
            addr      <= start_addr_read;
            line_base <= start_addr_read;
            col       <= '0;
            issued    <= '0;
            received  <= '0;
         end
      end else begin
         if (accept) begin
            issued <= issued + 16'd1;
            if (lw != 16'd0 && col + 16'd1 == lw) begin
               col       <= '0;
               line_base <= wrap(line_base + {14'd0, rw, 2'b00}, blk_start, blk_stop);
               addr      <= wrap(line_base + {14'd0, rw, 2'b00}, blk_start, blk_stop);
            end else begin
               col  <= col + 16'd1;
               addr <= wrap(addr + 32'd4, blk_start, blk_stop);
            end
         end
         if (push) received <= received + 16'd1;
      end
   end

   // NOTE: the FIFO storage has no reset; emptiness is tracked by the pointers
   // and count, and stream_data is forced to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= avm_m0_readdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_reader.sv
// Scoreboard bench for dma_reader: stimulus queues expected addresses and words,
// monitors pop and compare them on each accepted read and each stream pop.
module tb_dma_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] start_addr_block = '0;
   logic [31:0] stop_addr_block = '0;
   logic [31:0] start_addr_read = '0;
   logic [15:0] data_len = '0;
   logic [15:0] line_width = '0;
   logic [15:0] region_width = '0;
   logic [31:0] avm_m0_address;
   logic        avm_m0_read;
   logic        avm_m0_waitrequest = 1'b0;
   logic [31:0] avm_m0_readdata = '0;
   logic        avm_m0_readdatavalid = 1'b0;
   logic [31:0] stream_data;
   logic        stream_valid;
   logic        stream_ready = 1'b1;
   logic        busy;
   logic        irq;

   dma_reader #(.FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .start(start),
      .start_addr_block(start_addr_block), .stop_addr_block(stop_addr_block),
      .start_addr_read(start_addr_read), .data_len(data_len),
      .line_width(line_width), .region_width(region_width),
      .avm_m0_address(avm_m0_address), .avm_m0_read(avm_m0_read),
      .avm_m0_waitrequest(avm_m0_waitrequest), .avm_m0_readdata(avm_m0_readdata),
      .avm_m0_readdatavalid(avm_m0_readdatavalid),
      .stream_data(stream_data), .stream_valid(stream_valid),
      .stream_ready(stream_ready), .busy(busy), .irq(irq)
   );

   always #5 clk = ~clk;

   int          checks = 0, failures = 0, cyc = 0, acc_count = 0, irq_count = 0;
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   int          acc_cyc[$];
   logic        acc_q = 1'b0, inj_rdv = 1'b0;
   logic [31:0] a_q = '0, inj_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   always @(posedge clk) cyc++;

   // Slave: one-cycle read latency, plus a manual injection path.
   always begin
      @(negedge clk);
      acc_q = rst && avm_m0_read && !avm_m0_waitrequest;
      a_q   = avm_m0_address;
      @(posedge clk);
      #1;
      avm_m0_readdatavalid = acc_q || inj_rdv;
      avm_m0_readdata      = inj_rdv ? inj_data : mem_word(a_q);
   end

   always @(negedge clk) begin
      if (rst && avm_m0_read && !avm_m0_waitrequest) begin
         acc_count++;
         acc_cyc.push_back(cyc);
         if (exp_addr.size() == 0) fail("unexpected_read");
         else check("read_addr", avm_m0_address, exp_addr.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst && stream_valid && stream_ready) begin
         if (exp_data.size() == 0) fail("unexpected_stream_word");
         else check("stream_word", stream_data, exp_data.pop_front());
      end
   end

   always @(negedge clk) if (irq) irq_count++;

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   task automatic do_start(input logic [31:0] blo, input logic [31:0] bhi,
                           input logic [31:0] rd, input logic [15:0] len,
                           input logic [15:0] lw, input logic [15:0] rw,
                           output int sc);
      @(posedge clk);
      #1;
      start_addr_block = blo;
      stop_addr_block  = bhi;
      start_addr_read  = rd;
      data_len         = len;
      line_width       = lw;
      region_width     = rw;
      start            = 1'b1;
      sc               = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_irq(input int max, output int at);
      bit seen = 1'b0;
      at = -1;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clk);
         if (irq) begin
            seen = 1'b1;
            at   = cyc;
         end
      end
      if (!seen) fail("irq_timeout");
   endtask

   task automatic expect_words(input logic [31:0] addrs[$]);
      foreach (addrs[i]) begin
         exp_addr.push_back(addrs[i]);
         exp_data.push_back(mem_word(addrs[i]));
      end
   endtask

   task automatic check_idle_after(input string name, input int irq0);
      @(negedge clk);
      check({name, "_irq_low"}, 32'(irq), 32'd0);
      check({name, "_busy_low"}, 32'(busy), 32'd0);
      check({name, "_irq_pulses"}, 32'(irq_count - irq0), 32'd1);
      check({name, "_addr_drained"}, 32'(exp_addr.size()), 32'd0);
      check({name, "_data_drained"}, 32'(exp_data.size()), 32'd0);
   endtask

   initial begin
      int sc, at, ac0, irq0;
      logic [31:0] v[$];

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_read", 32'(avm_m0_read), 32'd0);
      check("rst_address", avm_m0_address, 32'd0);
      check("rst_stream_valid", 32'(stream_valid), 32'd0);
      check("rst_stream_data", stream_data, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      // Linear fetch, no stalls
      v = '{32'h100, 32'h104, 32'h108, 32'h10C};
      expect_words(v);
      ac0 = acc_count; irq0 = irq_count;
      do_start(32'h0, 32'h1000, 32'h100, 16'd4, 16'd0, 16'd0, sc);
      wait_irq(50, at);
      check("lin_irq_cycle", 32'(at - sc), 32'd8);
      check("lin_busy_at_irq", 32'(busy), 32'd1);
      check("lin_first_read_cycle", 32'(acc_cyc[ac0] - sc), 32'd1);
      check("lin_last_read_cycle", 32'(acc_cyc[ac0 + 3] - sc), 32'd4);
      check_idle_after("lin", irq0);

      // Line stride
      v = '{32'h200, 32'h204, 32'h220, 32'h224, 32'h240, 32'h244};
      expect_words(v);
      irq0 = irq_count;
      do_start(32'h0, 32'h1000, 32'h200, 16'd6, 16'd2, 16'd8, sc);
      wait_irq(60, at);
      check_idle_after("stride", irq0);

      // Wrap-around
      v = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
      expect_words(v);
      irq0 = irq_count;
      do_start(32'h1000, 32'h1010, 32'h1008, 16'd4, 16'd0, 16'd0, sc);
      wait_irq(50, at);
      check_idle_after("wrap", irq0);

      // Backpressure and credit, with an ignored start during ISSUE
      v.delete();
      for (int i = 0; i < 20; i++) v.push_back(32'h100 + 32'(4 * i));
      expect_words(v);
      stream_ready = 1'b0;
      ac0 = acc_count; irq0 = irq_count;
      do_start(32'h0, 32'h1000, 32'h100, 16'd20, 16'd0, 16'd0, sc);
      repeat (20) @(negedge clk);
      check("bp_reads_issued", 32'(acc_count - ac0), 32'd8);
      check("bp_read_low", 32'(avm_m0_read), 32'd0);
      check("bp_stream_valid", 32'(stream_valid), 32'd1);
      do_start(32'h0, 32'h1000, 32'h800, 16'd3, 16'd0, 16'd0, sc);
      repeat (3) @(negedge clk);
      check("ign_reads_issued", 32'(acc_count - ac0), 32'd8);
      check("ign_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1 stream_ready = 1'b1;
      wait_irq(200, at);
      check("bp_total_reads", 32'(acc_count - ac0), 32'd20);
      check_idle_after("bp", irq0);

      // Waitrequest stall on the second read
      v = '{32'h100, 32'h104, 32'h108};
      expect_words(v);
      ac0 = acc_count; irq0 = irq_count;
      do_start(32'h0, 32'h1000, 32'h100, 16'd3, 16'd0, 16'd0, sc);
      @(posedge clk);
      #1 avm_m0_waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_addr", avm_m0_address, 32'h104);
         check("stall_read", 32'(avm_m0_read), 32'd1);
         @(posedge clk);
         #1;
      end
      avm_m0_waitrequest = 1'b0;
      @(negedge clk);
      check("stall_addr_last", avm_m0_address, 32'h104);
      wait_irq(50, at);
      check("stall_gap", 32'(acc_cyc[ac0 + 1] - acc_cyc[ac0]), 32'd4);
      check_idle_after("stall", irq0);

      // Zero-length transfer
      ac0 = acc_count; irq0 = irq_count;
      do_start(32'h0, 32'h1000, 32'h100, 16'd0, 16'd0, 16'd0, sc);
      @(negedge clk);
      check("zero_irq_cycle1", 32'(irq), 32'd1);
      check("zero_busy_cycle1", 32'(busy), 32'd1);
      check("zero_no_reads", 32'(acc_count - ac0), 32'd0);
      check_idle_after("zero", irq0);

      // Reset mid-ISSUE, then late read data must not be streamed
      v.delete();
      for (int i = 0; i < 8; i++) v.push_back(32'h100 + 32'(4 * i));
      expect_words(v);
      stream_ready = 1'b0;
      ac0 = acc_count; irq0 = irq_count;
      do_start(32'h0, 32'h1000, 32'h100, 16'd8, 16'd0, 16'd0, sc);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_addr.delete();
      exp_data.delete();
      @(negedge clk);
      check("mid_rst_read", 32'(avm_m0_read), 32'd0);
      check("mid_rst_address", avm_m0_address, 32'd0);
      check("mid_rst_stream_valid", 32'(stream_valid), 32'd0);
      check("mid_rst_stream_data", stream_data, 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_irq", 32'(irq), 32'd0);
      @(posedge clk);
      #1;
      rst          = 1'b1;
      stream_ready = 1'b1;
      @(negedge clk);
      inj_data = 32'hBAD0_0001;
      inj_rdv  = 1'b1;
      repeat (2) @(negedge clk);
      inj_rdv = 1'b0;
      repeat (4) @(negedge clk);
      check("late_data_dropped", 32'(stream_valid), 32'd0);
      check("late_busy", 32'(busy), 32'd0);
      check("late_no_irq", 32'(irq_count - irq0), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
